// File: rtl/sqg_restrict.sv
// 2x2 restriction engine: scans a (2^BOX_IDX)^2 fine grid in quads and writes one sum/mean per quad.
// Optional macro SQG_ROUND_EN: mean mode rounds half-up instead of truncating.
module sqg_restrict #(
    parameter int BOX_IDX = 3,
    parameter int DW      = 8
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   start,
    input  logic                   mean_mode,
    input  logic [DW-1:0]          x,
    output logic                   rd_en,
    output logic [2*BOX_IDX-1:0]   rd_addr,
    output logic                   wen,
    output logic [2*BOX_IDX-3:0]   wr_addr,
    output logic [DW+1:0]          y,
    output logic                   busy,
    output logic                   done
);

    localparam int AW = 2*BOX_IDX;
    localparam int CW = 2*BOX_IDX-2;
    localparam int B  = BOX_IDX;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q;
    logic [AW-1:0]     cnt_q;
    logic              drain_q;
    logic              mode_q;
    logic              vld_q;
    logic [1:0]        ph_q;
    logic [CW-1:0]     cad_q;
    logic [DW+1:0]     acc_q;
    logic              rd_en_q;
    logic              wen_q;
    logic [CW-1:0]     wr_addr_q;
    logic [DW+1:0]     y_q;
    logic              busy_q;
    logic              done_q;

    logic [DW+1:0]     sum_d;
    logic [DW+1:0]     res_d;

    // counter layout: {cy, cx, phase}; phase bit0 -> fx LSB, bit1 -> fy LSB
    assign rd_addr = {cnt_q[B:2], cnt_q[0], cnt_q[AW-1:B+1], cnt_q[1]};

    always_comb begin
        sum_d = ((ph_q == 2'd0) ? '0 : acc_q) + {2'b00, x};
        res_d = sum_d;
        if (mode_q) begin
`ifdef SQG_ROUND_EN
            res_d = (sum_d + (DW+2)'(2)) >> 2;
`else
            res_d = sum_d >> 2;
`endif
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            drain_q   <= 1'b0;
            mode_q    <= 1'b0;
            vld_q     <= 1'b0;
            ph_q      <= 2'd0;
            cad_q     <= '0;
            acc_q     <= '0;
            rd_en_q   <= 1'b0;
            wen_q     <= 1'b0;
            wr_addr_q <= '0;
            y_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            wen_q  <= 1'b0;
            done_q <= 1'b0;
            // one-cycle delayed copy of the read issued last cycle, aligned with x
            vld_q  <= rd_en_q;
            ph_q   <= cnt_q[1:0];
            cad_q  <= cnt_q[AW-1:2];
            if (vld_q) begin
                acc_q <= sum_d;
                if (ph_q == 2'd3) begin
                    y_q       <= res_d;
                    wen_q     <= 1'b1;
                    wr_addr_q <= {cad_q[B-2:0], cad_q[CW-1:B-1]};
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_q  <= mean_mode;
                        cnt_q   <= '0;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        rd_en_q <= 1'b0;
                        drain_q <= 1'b0;
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    drain_q <= 1'b1;
                    if (drain_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_en   = rd_en_q;
    assign wen     = wen_q;
    assign wr_addr = wr_addr_q;
    assign y       = y_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
